// File: rtl/debounce_pkg.sv
// Shared constants for the key debounce logic.
//
// DEBOUNCE_10MS_100MHZ : stability window of 10 ms at a 100 MHz clock.
// DEBOUNCE_CNT_W       : counter width that can hold DEBOUNCE_10MS_100MHZ-1.
// key_state_e          : per-channel debounced state (IDLE = released,
//                        HELD = pressed). The encoding equals the level bit.
package debounce_pkg;

   localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
   localparam int DEBOUNCE_CNT_W       = 20;

   typedef enum logic {
      KEY_IDLE = 1'b0,
      KEY_HELD = 1'b1
   } key_state_e;

endpackage : debounce_pkg

// File: rtl/key_debounce_ch.sv
// Single debounce channel: two-flop synchroniser, polarity correction,
// stability counter, debounced level and one-cycle press/release strobes.
//
// Parameters
//   CNT_W         : stability counter width (STABLE_CYCLES <= 2**CNT_W).
//   STABLE_CYCLES : cycles a new sample value must persist to be accepted.
//   ACTIVE_LOW    : 1 inverts the synchronised input so pressed reads as 1.
// Ports
//   clk         in  system clock, rising edge
//   rst         in  synchronous active-high reset
//   key_raw     in  raw asynchronous key input
//   key_level   out debounced level (1 = pressed); this is the channel state
//   key_press   out one-cycle strobe on a rising debounced level
//   key_release out one-cycle strobe on a falling debounced level
module key_debounce_ch
   import debounce_pkg::*;
#(
   parameter int CNT_W         = DEBOUNCE_CNT_W,
   parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   key_state_e       state_q, state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             sample;

   always_comb begin
      sync1_d   = key_raw;
      sync2_d   = sync1_q;
      sample    = sync2_q ^ ACTIVE_LOW;
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;

      // The counter only runs while the sample disagrees with the state;
      // any agreement restarts it, so short glitches never get through.
      if (sample == logic'(state_q)) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         state_d   = sample ? KEY_HELD : KEY_IDLE;
         cnt_d     = '0;
         press_d   = sample;
         release_d = ~sample;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Synchroniser parks at the inactive raw value so a key held
         // through reset is seen as a fresh change afterwards.
         sync1_q   <= ACTIVE_LOW;
         sync2_q   <= ACTIVE_LOW;
         cnt_q     <= '0;
         state_q   <= KEY_IDLE;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_level   = logic'(state_q);
   assign key_press   = press_q;
   assign key_release = release_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: N_KEYS independent key_debounce_ch
// instances. Wiring only.
//
// Parameters
//   N_KEYS, CNT_W, STABLE_CYCLES, ACTIVE_LOW (see key_debounce_ch)
// Ports
//   clk         in  system clock, rising edge
//   rst         in  synchronous active-high reset
//   key_in      in  [N_KEYS] raw asynchronous key inputs
//   key_level   out [N_KEYS] debounced levels (1 = pressed)
//   key_press   out [N_KEYS] one-cycle press strobes
//   key_release out [N_KEYS] one-cycle release strobes
module key_debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter int CNT_W         = DEBOUNCE_CNT_W,
   parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .CNT_W         (CNT_W),
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .key_raw     (key_in[g]),
         .key_level   (key_level[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g])
      );
   end

endmodule : key_debounce_multi

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel key debouncer for the LED display control design. It sits between the raw board buttons or switches and the counter and display control logic. Each channel has a two-flop synchroniser, polarity correction and a per-channel stability counter, and debounces both press and release. Outputs are a clean level plus single-cycle press and release strobes per channel, replacing the single-channel, press-only filter.

## Interface
- N_KEYS, 4: number of independent channels.
- CNT_W, 20: stability counter width. Must satisfy STABLE_CYCLES ≤ 2^CNT_W.
- STABLE_CYCLES, 1_000_000: consecutive cycles a new input value must persist before it is accepted (10 ms at 100 MHz). Legal range ≥ 1.
- ACTIVE_LOW, 0: when 1, each raw input is inverted after synchronisation, so a pressed key reads as 1.
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  N_KEYS  raw asynchronous key inputs.
- key_level  out  N_KEYS  debounced level; 1 = pressed.
- key_press  out  N_KEYS  one-cycle strobe when key_level rises.
- key_release  out  N_KEYS  one-cycle strobe when key_level falls.

## Operation
- Synchroniser per channel: two flops, sync1 then sync2. The sample is s = sync2 XOR ACTIVE_LOW.
- Each channel holds a debounced level `lvl` and a counter `cnt`. Per cycle, first match wins:
  - rst: sync flops go to the inactive raw value (ACTIVE_LOW), `lvl` = 0, `cnt` = 0, strobes = 0.
  - s == lvl: `cnt` = 0. The bounce was rejected or there is no change.
  - cnt == STABLE_CYCLES-1: `lvl` = s and `cnt` = 0. key_press (if s=1) or key_release (if s=0) = 1 for this cycle only.
  - otherwise: `cnt` = cnt+1.
- Effectively a two-state machine per channel, IDLE(lvl=0) and HELD(lvl=1). The counter runs only while the sample disagrees with the state.
- Any return of s to lvl before the count completes restarts the count from 0. A glitch shorter than STABLE_CYCLES is never visible.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobe in the same cycle.
- Strobes are registered and mutually exclusive per channel. key_press and key_release are never both 1 on one channel.
- Reset mid-count discards the pending transition. After reset all channels read released, even if a key is physically held. A held key is then re-accepted as a press after STABLE_CYCLES+2 cycles.

## Timing
- Reset values: key_level = 0, key_press = 0, key_release = 0, all counters 0.
- Latency, for a raw change set up before clock edge E0 and held stable: key_level changes and the strobe asserts at edge E0+STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges including E0.
- Strobe width is exactly 1 cycle.
- Strobes coincide with the key_level change, in the cycle after that edge.
- Minimum accepted pulse width is STABLE_CYCLES cycles of synchronised sample. Release latency equals press latency.
- With STABLE_CYCLES = 1, any sample differing for one cycle is accepted. This is legal and used in the bench.

## Structure
- Shared package `debounce_pkg`:
  - localparam DEBOUNCE_10MS_100MHZ = 1_000_000
  - localparam DEBOUNCE_CNT_W = 20
- Sub-module `key_debounce_ch`:
  - one channel (synchroniser, counter, level, strobes), parameters CNT_W, STABLE_CYCLES and ACTIVE_LOW.
  - instantiated N_KEYS times in a generate loop. The top level contains only wiring.

## Test plan
All scenarios use STABLE_CYCLES = 4 unless stated.
- Reset with key_in = 1 held → all outputs 0 during reset. After release, key_level[0] rises and key_press[0] pulses 1 cycle at the 6th edge after rst deasserts.
- Clean press: key_in[0] 0→1 before E0 → key_level[0] = 1 and key_press[0] = 1 after E5. key_press[0] = 0 after E6. No release strobe.
- Bounce: key_in[1] toggles high for 3 cycles, low for 1, then high steadily → no strobe during the toggling. key_press[1] fires exactly once, 6 edges after the final rising edge.
- Release path plus ACTIVE_LOW = 1: key_in[2] held 0 (pressed) and then set to 1 → key_release[2] pulses once, key_level[2] goes 0 after 6 edges.
- Simultaneous events: key_in[0] and key_in[3] rise on the same edge → both key_press bits pulse in the same cycle. Other channels stay idle.
- Reset mid-count: rst = 1 for 1 cycle at count 2 of a press → no strobe, key_level stays 0. The count restarts, and the press is accepted 6 edges after rst drops.
